jtframe_cen_meter: RTL and testbench

Clock-enable measurement block: consumes a periodic clock-enable pulse train, such as the outputs of the 24 MHz enable generator, and measures its period in `clk` cycles. It reports lock once the period is stable and flags irregular or missing pulses. It sits beside the enable generator in the core's clocking logic, where it serves as an on-chip integrity monitor and feeds status to the debug/OSD path.

---
 rtl/jtframe_cen_pkg.sv | 22 ++
 rtl/jtframe_cen_period.sv | 72 +++++++
 rtl/jtframe_cen_meter.sv | 183 ++++++++++++++++++
 tb/tb_jtframe_cen_meter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_cen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_cen_pkg
// Purpose  : Shared definitions for the clock-enable period meter: FSM state
//            encoding and the glitch-counter width.
// Revision : 1.0 - initial release
// ============================================================================
package jtframe_cen_pkg;

  // Width of the saturating glitch/statistics counter
  localparam int ERRW = 8;

  // Meter FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOST   = 2'd3
  } cen_state_t;

endpackage
`default_nettype wire

// File: rtl/jtframe_cen_period.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_cen_period
// Purpose  : Saturating interval counter for the enable under test. Produces
//            the measured period p = cnt+1 and the tolerance comparisons the
//            meter FSM needs (against the acquisition reference and against
//            the locked period), plus the timeout and saturation conditions.
// Revision : 1.0 - initial release
// ============================================================================
module jtframe_cen_period #(
  parameter int CNTW = 8,
  parameter int TOL  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            cen,
  input  logic [CNTW-1:0] ref_per,
  input  logic [CNTW-1:0] period,
  output logic [CNTW-1:0] p,
  output logic            match_ref,
  output logic            match_per,
  output logic            timeout,
  output logic            sat
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW:0]   TOL_W   = (CNTW+1)'(TOL);
  localparam logic [CNTW:0]   ONE_W   = (CNTW+1)'(1);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW:0]   p_full;

  // |a-b| <= TOL, evaluated one bit wider than the counter so nothing wraps
  function automatic logic within_tol(input logic [CNTW:0] a, input logic [CNTW:0] b);
    logic [CNTW:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return (diff <= TOL_W);
  endfunction

  // Next count: restart on every enable or clear, otherwise count up and stick at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr || cen) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Interval counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign p_full    = {1'b0, cnt_q} + ONE_W;
  // A measured period never exceeds CNT_MAX: the meter leaves ACQ/LOCKED
  // before the counter can reach all-ones, so the low bits are exact.
  assign p         = p_full[CNTW-1:0];
  assign match_ref = within_tol(p_full, {1'b0, ref_per});
  assign match_per = within_tol(p_full, {1'b0, period});
  // Two full periods have elapsed on this edge without an enable
  assign timeout   = (p_full == {period, 1'b0});
  // The counter reaches (or already holds) all-ones on this edge
  assign sat       = (cnt_q >= (CNT_MAX - 1'b1));

endmodule
`default_nettype wire

// File: rtl/jtframe_cen_meter.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_cen_meter
// Purpose  : Measures the period of a clock-enable pulse train in clk cycles,
//            reports lock once LOCKN consecutive measurements agree within
//            TOL, and flags glitches and missing pulses.
// Options  : JTFRAME_CEN_METER_STATS_EN - enables the saturating err_cnt
//            glitch/loss counter; otherwise err_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module jtframe_cen_meter
  import jtframe_cen_pkg::*;
#(
  parameter int CNTW  = 8,
  parameter int LOCKN = 4,
  parameter int TOL   = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            clr,
  output logic [CNTW-1:0] period,
  output logic            period_vld,
  output logic            locked,
  output logic            lost,
  output logic [ERRW-1:0] err_cnt
);

  localparam logic [3:0] LOCKN_W = 4'(LOCKN);

  cen_state_t      state_q, state_d;
  logic [CNTW-1:0] ref_q, ref_d;
  logic [3:0]      mcnt_q, mcnt_d;
  logic [CNTW-1:0] period_q, period_d;
  logic            vld_q, vld_d;
  logic            locked_q, locked_d;
  logic            lost_q, lost_d;

  logic [CNTW-1:0] meas;
  logic            match_ref, match_per, timeout, sat;

  jtframe_cen_period #(
    .CNTW (CNTW),
    .TOL  (TOL)
  ) u_period (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .cen       (cen),
    .ref_per   (ref_q),
    .period    (period_q),
    .p         (meas),
    .match_ref (match_ref),
    .match_per (match_per),
    .timeout   (timeout),
    .sat       (sat)
  );

  // FSM next state and output values; clr overrides any enable in the same cycle
  always_comb begin
    logic [3:0] mcnt_nx;
    state_d  = state_q;
    ref_d    = ref_q;
    mcnt_d   = mcnt_q;
    period_d = period_q;
    vld_d    = 1'b0;
    lost_d   = lost_q;
    mcnt_nx  = mcnt_q;
    if (clr) begin
      state_d  = ST_IDLE;
      ref_d    = '0;
      mcnt_d   = '0;
      period_d = '0;
      lost_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cen) state_d = ST_ACQ;
        end
        ST_ACQ: begin
          if (cen) begin
            if (match_ref) begin
              mcnt_nx = mcnt_q + 1'b1;
            end else begin
              ref_d   = meas;
              mcnt_nx = 4'd1;
            end
            mcnt_d = mcnt_nx;
            if (mcnt_nx >= LOCKN_W) begin
              state_d  = ST_LOCKED;
              period_d = ref_d;
            end
          end else if (sat) begin
            state_d = ST_LOST;
            lost_d  = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (cen) begin
            if (match_per) begin
              vld_d    = 1'b1;
              period_d = meas;
            end else begin
              state_d = ST_ACQ;
              ref_d   = meas;
              mcnt_d  = 4'd1;
            end
          end else if (timeout || sat) begin
            // sat covers long periods whose double cannot be reached by the counter
            state_d = ST_LOST;
            lost_d  = 1'b1;
          end
        end
        ST_LOST: begin
          if (cen) begin
            state_d = ST_ACQ;
            mcnt_d  = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // FSM and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ref_q    <= '0;
      mcnt_q   <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      mcnt_q   <= mcnt_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      locked_q <= locked_d;
      lost_q   <= lost_d;
    end
  end

  assign period     = period_q;
  assign period_vld = vld_q;
  assign locked     = locked_q;
  assign lost       = lost_q;

`ifdef JTFRAME_CEN_METER_STATS_EN
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;
  logic            err_evt;

  // Count each drop out of lock and each entry into LOST, saturating at all-ones
  always_comb begin
    err_evt   = ((state_q == ST_LOCKED) && (state_d == ST_ACQ)) ||
                ((state_q != ST_LOST)   && (state_d == ST_LOST));
    err_cnt_d = err_cnt_q;
    if (clr) begin
      err_cnt_d = '0;
    end else if (err_evt && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Statistics register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jtframe_cen_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtframe_cen_meter
// Purpose  : Self-checking bench for jtframe_cen_meter (CNTW=8 main instance
//            plus a CNTW=3 instance for counter saturation). Expected output
//            vectors are queued as stimulus is driven and compared after the
//            clock edge that produces them.
// Options  : JTFRAME_CEN_METER_STATS_EN - expected err_cnt follows the build.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jtframe_cen_meter;

`ifdef JTFRAME_CEN_METER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, cen, clr, cen3, clr3;
  logic [7:0] period;
  logic       period_vld, locked, lost;
  logic [7:0] err_cnt;
  logic [2:0] period3;
  logic       period_vld3, locked3, lost3;
  logic [7:0] err_cnt3;

  logic [18:0] obs;
  logic [13:0] obs3;
  logic [18:0] exp_q[$];
  logic [13:0] exp3_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtframe_cen_meter #(.CNTW(8), .LOCKN(4), .TOL(0)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .clr(clr),
    .period(period), .period_vld(period_vld), .locked(locked),
    .lost(lost), .err_cnt(err_cnt)
  );

  jtframe_cen_meter #(.CNTW(3), .LOCKN(4), .TOL(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .cen(cen3), .clr(clr3),
    .period(period3), .period_vld(period_vld3), .locked(locked3),
    .lost(lost3), .err_cnt(err_cnt3)
  );

  assign obs  = {locked, period_vld, lost, period, err_cnt};
  assign obs3 = {locked3, period_vld3, lost3, period3, err_cnt3};

  function automatic logic [18:0] pk(input bit l, input bit v, input bit lo,
                                     input logic [7:0] p, input logic [7:0] e);
    return {l, v, lo, p, e};
  endfunction

  function automatic logic [13:0] pk3(input bit l, input bit v, input bit lo,
                                      input logic [2:0] p, input logic [7:0] e);
    return {l, v, lo, p, e};
  endfunction

  function automatic logic [7:0] ev(input int n);
    return STATS ? 8'(n) : 8'd0;
  endfunction

  task automatic test_reset();
    logic [18:0] e;
    logic [13:0] e3;
    rst_n = 1'b0; cen = 1'b0; clr = 1'b0; cen3 = 1'b0; clr3 = 1'b0;
    exp_q.push_back(pk(0, 0, 0, 8'd0, 8'd0));
    exp3_q.push_back(pk3(0, 0, 0, 3'd0, 8'd0));
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset got=%h want=%h", obs, e); end
    e3 = exp3_q.pop_front(); checks++;
    if (obs3 !== e3) begin errors++; $display("FAIL reset3 got=%h want=%h", obs3, e3); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Clear, then a regular pulse train of spacing sp; ends with sp-1 idle cycles
  task automatic test_lock(input int sp, input int np, input string nm);
    logic [18:0] e;
    bit c_en;
    int k;
    exp_q.push_back(pk(0, 0, 0, 8'd0, 8'd0));
    clr = 1'b1; cen = 1'b0;
    @(posedge clk); #1 clr = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s_clr got=%h want=%h", nm, obs, e); end
    for (int c = 0; c < np*sp; c++) begin
      c_en = ((c % sp) == 0);
      k    = c/sp + 1;
      exp_q.push_back(pk(k >= 5, c_en && (k >= 6), 0, (k >= 5) ? 8'(sp) : 8'd0, 8'd0));
      cen = c_en;
      @(posedge clk); #1 cen = 1'b0;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s c=%0d got=%h want=%h", nm, c, obs, e); end
    end
  endtask

  // From lock at period 4 (aligned), one interval of 5 then relock on intervals of 4
  task automatic test_glitch();
    logic [18:0] e;
    bit c_en;
    int j;
    exp_q.push_back(pk(1, 0, 0, 8'd4, 8'd0));
    cen = 1'b0;
    @(posedge clk); #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL glitch_gap got=%h want=%h", obs, e); end
    exp_q.push_back(pk(0, 0, 0, 8'd4, ev(1)));
    cen = 1'b1;
    @(posedge clk); #1 cen = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL glitch_hit got=%h want=%h", obs, e); end
    for (int c = 0; c < 23; c++) begin
      c_en = ((c % 4) == 3);
      j    = (c + 1) / 4;
      exp_q.push_back(pk(j >= 4, c_en && (j >= 5), 0, 8'd4, ev(1)));
      cen = c_en;
      @(posedge clk); #1 cen = 1'b0;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL relock c=%0d got=%h want=%h", c, obs, e); end
    end
  endtask

  // clr together with cen while locked: everything clears and that cen is not an IDLE exit
  task automatic test_clr_cen();
    logic [18:0] e;
    bit c_en;
    int j;
    exp_q.push_back(pk(0, 0, 0, 8'd0, 8'd0));
    clr = 1'b1; cen = 1'b1;
    @(posedge clk); #1 clr = 1'b0; cen = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL clr_cen got=%h want=%h", obs, e); end
    for (int c = 0; c < 27; c++) begin
      c_en = ((c % 4) == 3);
      j    = (c + 1) / 4;
      exp_q.push_back(pk(j >= 5, c_en && (j >= 6), 0, (j >= 5) ? 8'd4 : 8'd0, 8'd0));
      cen = c_en;
      @(posedge clk); #1 cen = 1'b0;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL clr_relock c=%0d got=%h want=%h", c, obs, e); end
    end
  endtask

  // Locked at 4 with 3 idle cycles already elapsed; LOST on the 8th cycle without cen
  task automatic test_timeout();
    logic [18:0] e;
    for (int i = 4; i <= 12; i++) begin
      exp_q.push_back(pk(i < 8, 0, i >= 8, 8'd4, (i >= 8) ? ev(1) : 8'd0));
      cen = 1'b0;
      @(posedge clk); #1;
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL timeout i=%0d got=%h want=%h", i, obs, e); end
    end
  endtask

  // Relock, then assert rst_n mid-cycle and expect immediate clearing
  task automatic test_async_reset();
    logic [18:0] e;
    clr = 1'b1; cen = 1'b0;
    @(posedge clk); #1 clr = 1'b0;
    for (int c = 0; c < 24; c++) begin
      cen = ((c % 4) == 0);
      @(posedge clk); #1 cen = 1'b0;
    end
    exp_q.push_back(pk(1, 0, 0, 8'd4, 8'd0));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL pre_rst got=%h want=%h", obs, e); end
    #3 rst_n = 1'b0;
    exp_q.push_back(pk(0, 0, 0, 8'd0, 8'd0));
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL async_rst got=%h want=%h", obs, e); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // CNTW=3 instance with a 13-cycle pattern: counter saturates, LOST, recovery attempts
  task automatic test_cntw3();
    logic [13:0] e3;
    int n;
    for (int c = 0; c < 39; c++) begin
      n = int'(c >= 7) + int'(c >= 20) + int'(c >= 33);
      exp3_q.push_back(pk3(0, 0, c >= 7, 3'd0, ev(n)));
      cen3 = ((c % 13) == 0);
      @(posedge clk); #1 cen3 = 1'b0;
      e3 = exp3_q.pop_front(); checks++;
      if (obs3 !== e3) begin errors++; $display("FAIL cntw3 c=%0d got=%h want=%h", c, obs3, e3); end
    end
  endtask

  initial begin
    test_reset();
    test_lock(4, 8, "lock4");
    test_glitch();
    test_clr_cen();
    test_timeout();
    test_async_reset();
    test_lock(13, 6, "lock13");
    test_lock(1, 8, "const_cen");
    test_cntw3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
